ternary_word_reduce: RTL and testbench

- Streaming reducer for packed ternary words, built on the team's two-wire trit encoding.
- Accepts a packet of N-trit words over a valid/ready handshake and folds them trit-wise with one of four ternary operators: MIN, MAX, CONSENSUS or ANY.
- Presents the reduced word, beat count and error flag on a backpressured output port.
- Generalises the single-trit combinational operators to parametrised width, with packet sequencing and buffering.

---
 rtl/ternary_word_reduce_pkg.sv | 27 ++
 rtl/ternary_word_reduce_trit_op.sv | 37 +++
 rtl/ternary_word_reduce.sv | 118 +++++++++++
 tb/tb_ternary_word_reduce.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ternary_word_reduce_pkg.sv
// Shared types for the packed-ternary reducer: trit codes, operator and FSM enums.
// Two-wire trit code {hi,lo}: 00=0, 01=1, 10=2, 11 invalid (treated as 2).
package ternary_pkg;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_ONE  = 2'b01;
  localparam logic [1:0] T_TWO  = 2'b10;

  typedef enum logic [1:0] {
    OP_MIN  = 2'd0,
    OP_MAX  = 2'd1,
    OP_CONS = 2'd2,
    OP_ANY  = 2'd3
  } tern_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } tern_state_e;

  // The invalid code 11 folds onto 2 so arithmetic never sees a value above 2.
  function automatic logic [1:0] trit_decode(input logic [1:0] code);
    return (code == 2'b11) ? T_TWO : code;
  endfunction

endpackage

// File: rtl/ternary_word_reduce_trit_op.sv
// Single-trit combinational ternary operator (MIN, MAX, CONSENSUS, ANY).
// Inputs may carry the invalid code 11; it is decoded as 2. Output is always a valid code.
module ternary_trit_op
  import ternary_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  tern_op_e   i_op,
  output logic [1:0] o_y
);

  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_sum;

  assign w_a   = trit_decode(i_a);
  assign w_b   = trit_decode(i_b);
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    o_y = T_ZERO;
    case (i_op)
      OP_MIN:  o_y = (w_a < w_b) ? w_a : w_b;
      OP_MAX:  o_y = (w_a > w_b) ? w_a : w_b;
      OP_CONS: o_y = (w_a == w_b) ? w_a : T_ONE;
      OP_ANY: begin
        // a+b-1 clamped to [0,2]
        if (w_sum == 3'd0)      o_y = T_ZERO;
        else if (w_sum >= 3'd3) o_y = T_TWO;
        else                    o_y = w_sum[1:0] - 2'd1;
      end
      default: o_y = T_ZERO;
    endcase
  end

endmodule

// File: rtl/ternary_word_reduce.sv
// Streaming trit-wise reducer of N-trit packets with a registered, backpressured result port.
// Build option TERN_INVALID_CHECK_EN: flag packets containing the invalid trit code 11 on out_err.
module ternary_word_reduce
  import ternary_pkg::*;
#(
  parameter int TRITS = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*TRITS-1:0]   in_data,
  input  logic [1:0]           in_op,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*TRITS-1:0]   out_data,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_err
);

  tern_state_e          r_state;
  tern_op_e             r_op;
  logic [2*TRITS-1:0]   r_acc;
  logic [CNT_W-1:0]     r_count;
  logic                 r_err;
  logic                 r_out_valid;
  logic [2*TRITS-1:0]   r_out_data;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_err;

  logic [2*TRITS-1:0]   w_fold;
  logic [CNT_W-1:0]     w_count_inc;
  logic                 w_beat_err;

  for (genvar g = 0; g < TRITS; g++) begin : g_trit
    ternary_trit_op u_trit_op (
      .i_a  (r_acc[2*g +: 2]),
      .i_b  (in_data[2*g +: 2]),
      .i_op (r_op),
      .o_y  (w_fold[2*g +: 2])
    );
  end

  assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

`ifdef TERN_INVALID_CHECK_EN
  logic [TRITS-1:0] w_trit_bad;
  for (genvar g = 0; g < TRITS; g++) begin : g_chk
    assign w_trit_bad[g] = &in_data[2*g +: 2];
  end
  assign w_beat_err = |w_trit_bad;
`else
  assign w_beat_err = 1'b0;
`endif

  // Ready depends on state alone, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_err   = r_out_err;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MIN;
      r_acc       <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_acc   <= in_data;
          r_op    <= tern_op_e'(in_op);
          r_count <= CNT_W'(1);
          r_err   <= w_beat_err;
          if (in_last) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_count <= CNT_W'(1);
            r_out_err   <= w_beat_err;
          end else begin
            r_state <= S_ACC;
          end
        end
        S_ACC: if (in_valid) begin
          r_acc   <= w_fold;
          r_count <= w_count_inc;
          r_err   <= r_err | w_beat_err;
          if (in_last) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_out_data  <= w_fold;
            r_out_count <= w_count_inc;
            r_out_err   <= r_err | w_beat_err;
          end
        end
        S_HOLD: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_count <= '0;
          r_out_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_word_reduce.sv
// Directed bench for ternary_word_reduce (TRITS=4); a CNT_W=2 twin checks counter saturation.
module tb_ternary_word_reduce;
  import ternary_pkg::*;

  localparam int TRITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic [2*TRITS-1:0]  in_data = '0;
  logic [1:0]          in_op = '0;
  logic                in_last = 1'b0;
  logic                out_ready = 1'b0;

  logic                in_ready, out_valid, out_err;
  logic [2*TRITS-1:0]  out_data;
  logic [7:0]          out_count;
  logic                in_ready_c2, out_valid_c2, out_err_c2;
  logic [2*TRITS-1:0]  out_data_c2;
  logic [1:0]          out_count_c2;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err_bit;

  always #5 clk = ~clk;

  ternary_word_reduce #(.TRITS(TRITS), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_err(out_err)
  );

  ternary_word_reduce #(.TRITS(TRITS), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c2), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid_c2), .out_ready(out_ready),
    .out_data(out_data_c2), .out_count(out_count_c2), .out_err(out_err_c2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word written t3..t0, each argument a trit code 0..3.
  function automatic logic [7:0] tw(input int t3, input int t2, input int t1, input int t0);
    logic [1:0] a, b, c, d;
    a = t3[1:0]; b = t2[1:0]; c = t1[1:0]; d = t0[1:0];
    return {a, b, c, d};
  endfunction

  // Offers one beat and returns #1 after the edge on which it was accepted.
  task automatic send(input logic [7:0] d, input logic [1:0] op, input logic last);
    int k;
    in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_op = '0;
  endtask

  task automatic take(input string tag, input logic [7:0] exp_data, input int exp_cnt,
                      input logic exp_e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, "_err"}, 32'(out_err), 32'(exp_e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    check({tag, "_cleared"}, 32'(out_data) | 32'(out_count), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_outs"}, {22'd0, out_err, out_count, out_data}, 32'd0);
  endtask

  initial begin
`ifdef TERN_INVALID_CHECK_EN
    exp_err_bit = 1'b1;
`else
    exp_err_bit = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("por");

    send(tw(0,1,2,0), OP_MAX, 1'b0);
    send(tw(2,1,0,1), OP_MIN, 1'b1);
    take("max", tw(2,1,2,1), 2, 1'b0);

    send(tw(0,1,2,0), OP_MIN, 1'b0);
    send(tw(2,1,0,1), OP_MAX, 1'b1);
    take("min", tw(0,1,0,0), 2, 1'b0);

    send(tw(0,1,2,0), OP_CONS, 1'b0);
    send(tw(2,1,0,1), OP_ANY, 1'b1);
    take("cons", tw(1,1,1,1), 2, 1'b0);

    send(tw(2,2,2,2), OP_ANY, 1'b0);
    send(tw(0,0,0,0), OP_MIN, 1'b0);
    send(tw(0,1,2,0), OP_MIN, 1'b1);
    // Backpressure: an offered beat must not be taken and the result must not move.
    in_valid = 1'b1; in_data = tw(1,1,1,1); in_op = OP_MIN; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(tw(0,1,2,0)));
    end
    in_valid = 1'b0; in_last = 1'b0;
    take("any", tw(0,1,2,0), 3, 1'b0);

    send(tw(1,2,0,1), OP_CONS, 1'b1);
    take("single", tw(1,2,0,1), 1, 1'b0);

    for (int i = 0; i < 6; i++) send(tw(1,1,1,1), OP_MIN, i == 5);
    check("sat_c2_count", 32'(out_count_c2), 32'd3);
    check("sat_c2_data", 32'(out_data_c2), 32'(tw(1,1,1,1)));
    take("sat", tw(1,1,1,1), 6, 1'b0);

    send(tw(2,2,2,2), OP_MAX, 1'b0);
    send(tw(2,2,2,2), OP_MAX, 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check_reset_state("rst_mid");
    send(tw(0,1,2,0), OP_MIN, 1'b1);
    take("after_rst_mid", tw(0,1,2,0), 1, 1'b0);

    send(tw(1,1,1,1), OP_MAX, 1'b1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check_reset_state("rst_hold");
    send(tw(2,0,0,0), OP_MAX, 1'b1);
    take("after_rst_hold", tw(2,0,0,0), 1, 1'b0);

    send(tw(0,1,2,0), OP_MAX, 1'b0);
    send(tw(0,0,0,3), OP_MIN, 1'b1);
    take("inval", tw(0,1,2,2), 2, exp_err_bit);
    send(tw(1,2,0,1), OP_CONS, 1'b1);
    take("clean", tw(1,2,0,1), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
